// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side (fetch, load/store) and memory-side signals for mem_arbiter.
// Purely combinational wiring; no state lives here.
// slave modport = arbiter view, master modport = requesters + memory model view.
interface mem_arbiter_if;
    // fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    // load/store port
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    // memory side
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    // current owner, one-hot {ls, if}
    logic [1:0]  grant;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  mem_rdata,
        output if_rdata, if_ack,
        output ls_rdata, ls_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output grant
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output mem_rdata,
        input  if_rdata, if_ack,
        input  ls_rdata, ls_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) single-port memory arbiter; ls wins ties unless MEM_ARB_ROUND_ROBIN_EN alternates them.
// Latency: ack rises WAIT_CYCLES+1 edges after the granting edge; one access in flight, no pipelining.
// Backpressure: requesters hold req until their ack; a losing requester simply waits in IDLE for the next grant.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2   // memory wait states, 0..15 (counter is 4 bits)
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [1:0]  grant_q;
    logic        mem_en_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [31:0] if_rdata_q;
    logic [31:0] ls_rdata_q;
    logic        if_ack_q;
    logic        ls_ack_q;

    logic        any_req;
    logic        pick_ls;   // winner if a grant happens this edge: 1 = ls, 0 = if

    assign any_req = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Owner of the most recent grant; starts as ls so the first tie goes to fetch.
    logic last_ls;

    // On a tie, hand the access to whoever did not get the previous one.
    always_comb begin
        pick_ls = bus.ls_req;
        if (bus.if_req && bus.ls_req) begin
            pick_ls = ~last_ls;
        end
    end

    // Remember the owner at every grant so the next tie alternates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ls <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_ls <= pick_ls;
        end
    end
`else
    // Fixed priority: load/store beats fetch whenever it is asking.
    always_comb begin
        pick_ls = bus.ls_req;
    end
`endif

    // Main sequencer: grant/latch in IDLE, count wait states in ACCESS, pulse ack in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            grant_q     <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            if_rdata_q  <= 32'd0;
            ls_rdata_q  <= 32'd0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        // Everything the memory sees is captured here, so requester
                        // inputs are free to move for the rest of the access.
                        mem_en_q <= 1'b1;
                        wait_cnt <= WAIT_INIT;
                        state    <= ACCESS;
                        if (pick_ls) begin
                            grant_q     <= 2'b10;
                            mem_we_q    <= bus.ls_we;
                            mem_addr_q  <= bus.ls_addr;
                            mem_wdata_q <= bus.ls_wdata;
                            mem_be_q    <= bus.ls_be;
                        end else begin
                            grant_q     <= 2'b01;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= 32'd0;
                            mem_be_q    <= 4'b1111;
                        end
                    end
                end

                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        // Last access cycle: memory data is valid now.
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state    <= RESP;
                        if (grant_q[1]) begin
                            ls_ack_q <= 1'b1;
                            // A store returns nothing; keep the last load result.
                            if (!mem_we_q) begin
                                ls_rdata_q <= bus.mem_rdata;
                            end
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                RESP: begin
                    // Single-cycle ack; owner released so IDLE can re-arbitrate next edge.
                    if_ack_q <= 1'b0;
                    ls_ack_q <= 1'b0;
                    grant_q  <= 2'b00;
                    state    <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    grant_q  <= 2'b00;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if_ack_q <= 1'b0;
                    ls_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.ls_ack    = ls_ack_q;

endmodule
